param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, 8, counter width in bits (2..32).
REQ-002 Parameter LO, 0, lower count bound (unsigned, LO < HI).
REQ-003 Parameter HI, 2**WIDTH-1, upper count bound (unsigned, HI <= 2**WIDTH-1).
REQ-004 Parameter PRESCALE, 1, enabled cycles per count step (1..256).
REQ-005 Port clk input 1 clock; all state updates on its rising edge.
REQ-006 Port rst input 1 reset, synchronous, active-high.
REQ-007 Port en input 1 count enable; gates the prescaler and the counter.
REQ-008 Port load input 1 parallel load strobe.
REQ-009 Port up input 1 direction: 1 counts up, 0 counts down.
REQ-010 Port din input WIDTH load value.
REQ-011 Port sat input 1 saturate select; present only with SAT_EN.
REQ-012 Port count output WIDTH registered count.
REQ-013 Port at_hi output 1 combinational flag, count == HI.
REQ-014 Port at_lo output 1 combinational flag, count == LO.
REQ-015 Port wrap output 1 registered one-cycle pulse, count wrapped on previous edge.

Function
REQ-016 Priority per edge: rst > load > step > hold.
REQ-017 Load: count <= din clamped to [LO,HI] (din<LO -> LO, din>HI -> HI); load ignores en; load clears prescaler phase.
REQ-018 Step: occurs on an edge where en=1, load=0 and prescaler phase == PRESCALE-1; PRESCALE=1 steps every enabled cycle.
REQ-019 Prescaler: phase counter increments on every en=1, load=0 cycle, returns to 0 after PRESCALE-1; holds when en=0; a direction change does not clear it.
REQ-020 Step up: count <= count+1 when count<HI; at HI, count <= LO and wrap <= 1.
REQ-021 Step down: count <= count-1 when count>LO; at LO, count <= HI and wrap <= 1.
REQ-022 wrap is 0 on every edge that is not a wrapping step, including load and hold edges.
REQ-023 All arithmetic in WIDTH bits; no intermediate overflow reaches count for HI = 2**WIDTH-1.
REQ-024 count is never outside [LO,HI] after the first post-reset edge.

Reset
REQ-025 On rst=1 at an edge: count <= LO, wrap <= 0, prescaler phase <= 0, regardless of load/en.
REQ-026 rst asserted mid-prescale or mid-count discards all state; the first step after release needs a full PRESCALE enabled cycles.

Configuration
REQ-027 Macro SAT_EN: when defined, port sat exists; sat=1 makes a step at HI (up) or LO (down) hold count with wrap=0; sat=0 wraps per REQ-020/021.
REQ-028 Without SAT_EN: port sat absent, behaviour always wraps.

Structure
REQ-029 Package counter_pkg holds the direction enum (DIR_DOWN=0, DIR_UP=1) and the PRESCALE_W width function (clog2 of PRESCALE, minimum 1).
REQ-030 Sub-module step_gen implements the prescaler: inputs clk, rst, en, clr; output step pulse; parameter PRESCALE.
REQ-031 Parameter legality (LO<HI, HI within WIDTH, PRESCALE range) checked at elaboration with a fatal error.

Verification
REQ-032 WIDTH=4, LO=2, HI=12, PRESCALE=1: rst 2 cycles -> count=2, wrap=0, at_lo=1.
REQ-033 Same config: load din=15 -> count=12; load din=0 -> count=2 (clamped).
REQ-034 Load 10, up=1, en=1 for 4 cycles -> 11, 12, 2 (wrap=1 one cycle), 3; then up=0 for 2 cycles -> 2, 12 with wrap=1.
REQ-035 SAT_EN, sat=1: load 12, up=1, en=1 for 3 cycles -> count stays 12, wrap stays 0; up=0 sat=1 at 2 -> holds 2.
REQ-036 PRESCALE=3: load 5, en=1 -> count 6 after 3 enabled cycles; en=0 for 2 cycles mid-phase -> no step, phase held; load mid-phase restarts 3-cycle count.
REQ-037 rst asserted simultaneously with load din=7 and en=1 -> count=LO, wrap=0; bench asserts count within [LO,HI] every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the parameterised up/down counter.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Width of the prescaler phase register; never narrower than one bit.
  function automatic int PRESCALE_W(input int unsigned p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/step_gen.sv
// Prescaler: emits a one-cycle step every PRESCALE enabled, non-cleared cycles.
module step_gen
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = PRESCALE_W(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_reg;
  logic [PW-1:0] phase_next;

  always_comb begin
    phase_next = phase_reg;
    if (clr) begin
      phase_next = '0;
    end else if (en) begin
      phase_next = (phase_reg == LAST) ? '0 : phase_reg + PW'(1);
    end
  end

  assign step = en && !clr && (phase_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Bounded up/down counter with prescaler, clamped load and wrap pulse.
// Define SAT_EN to add the sat input, which holds at the bounds instead of wrapping.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LO       = 0,
  parameter int unsigned HI       = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
`ifdef SAT_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             at_hi,
  output logic             at_lo,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH must be 2..32");
  end
  if (LO >= HI) begin : g_bad_bounds
    $fatal(1, "param_updown_counter: LO must be below HI");
  end
  if (64'(HI) >= (64'd1 << WIDTH)) begin : g_bad_hi
    $fatal(1, "param_updown_counter: HI does not fit in WIDTH bits");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $fatal(1, "param_updown_counter: PRESCALE must be 1..256");
  end

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic             step;
  logic             hold_at_bound;
  dir_t             dir;

  assign dir = up ? DIR_UP : DIR_DOWN;

`ifdef SAT_EN
  assign hold_at_bound = sat;
`else
  assign hold_at_bound = 1'b0;
`endif

  step_gen #(.PRESCALE(PRESCALE)) u_step_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  // Bound comparisons are made before any +/-1, so HI at the top of the range never overflows.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      if (din < LO_V)      count_next = LO_V;
      else if (din > HI_V) count_next = HI_V;
      else                 count_next = din;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (count_reg != HI_V) begin
          count_next = count_reg + WIDTH'(1);
        end else if (!hold_at_bound) begin
          count_next = LO_V;
          wrap_next  = 1'b1;
        end
      end else begin
        if (count_reg != LO_V) begin
          count_next = count_reg - WIDTH'(1);
        end else if (!hold_at_bound) begin
          count_next = HI_V;
          wrap_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= LO_V;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;
  assign at_hi = (count_reg == HI_V);
  assign at_lo = (count_reg == LO_V);

endmodule
